fall_tick_generator: RTL and testbench
======================================

FALL_TICK_GENERATOR -- requirements
Module: fall_tick_generator

Interface
REQ-001 The block SHALL have parameter DIV, default 5000000, meaning base prescaler period in clock cycles (10 Hz step at 50 MHz).
REQ-002 The block SHALL have parameter DELAY2, default 30, meaning the number of column-1 steps before column 2 is launched.
REQ-003 The block SHALL have parameter DELAY3, default 60, meaning the number of column-1 steps before column 3 is launched; DELAY3 > DELAY2 >= 1.
REQ-004 The block SHALL have port clock, input, 1, the system clock (CLOCK_50).
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port restart, input, 1, synchronous active-high game-restart pulse (driven from reset_signal).
REQ-007 The block SHALL have port game_over, input, 3, per-column game-over flags; bit i is for column i+1.
REQ-008 The block SHALL have port speed, input, 2, speed level; effective period DIV_EFF = DIV >> speed.
REQ-009 The block SHALL have port step, output, 3, one-cycle fall-step enables, one per column.
REQ-010 The block SHALL have port active, output, 3, column-launched flags.
REQ-011 The block SHALL have port state, output, 2, encoded FSM state.

Function
REQ-012 The FSM SHALL have states IDLE=00, RUN=01 and HALT=10; encoding 11 is unreachable and SHALL recover to IDLE on the next clock.
REQ-013 In IDLE the block SHALL hold the prescaler and launch counter at 0, with step=000 and active=000; restart SHALL move the FSM to RUN on the next edge.
REQ-014 On entry to RUN the block SHALL set prescaler=0, launch counter=0 and active=001.
REQ-015 In RUN the prescaler SHALL count 0..DIV_EFF-1 and wrap; a wrap edge is one where prescaler==DIV_EFF-1.
REQ-016 The block SHALL sample speed only at a prescaler wrap or at entry to RUN; a speed change mid-period SHALL NOT truncate or extend the current period.
REQ-017 On each wrap edge step SHALL become active-before-edge for exactly one cycle; otherwise step SHALL be 000; step is a registered output.
REQ-018 The first step[0] SHALL be high exactly DIV_EFF cycles after the first cycle in RUN.
REQ-019 On each wrap edge the launch counter SHALL increment and saturate at DELAY3, with width = clog2(DELAY3+1).
REQ-020 active[1] SHALL set on the wrap edge where the counter reaches DELAY2, so that the first step[1] coincides with the (DELAY2+1)-th step[0].
REQ-021 active[2] SHALL set on the wrap edge where the counter reaches DELAY3, so that the first step[2] coincides with the (DELAY3+1)-th step[0].
REQ-022 In RUN, any game_over bit high SHALL move the FSM to HALT on the next edge; step SHALL be forced to 000 from that edge, including a coincident wrap.
REQ-023 In HALT the block SHALL freeze the prescaler, counter and active, and hold step=000; only restart SHALL leave HALT, going to RUN with REQ-014 applied.
REQ-024 Restart while in RUN SHALL re-enter RUN with REQ-014 applied; any pending wrap that edge SHALL be discarded.
REQ-025 When restart and game_over are high on the same edge, restart SHALL win.
REQ-026 A game_over bit for a column not yet active SHALL still halt the block.
REQ-027 When DIV_EFF=1, step SHALL be high every cycle in RUN, with no gaps.

Reset
REQ-028 reset_n low SHALL immediately and asynchronously force state=IDLE, step=000, active=000, prescaler=0 and counter=0, independent of clock.
REQ-029 Deassertion of reset_n SHALL leave the block in IDLE until restart; reset_n asserted mid-RUN SHALL abort with no further step pulses.

Verification
REQ-030 Bench params SHALL be DIV=4, DELAY2=3, DELAY3=6; scenario: reset, speed=0, restart at cycle 10 -> state=01 at cycle 11, step[0] pulses at cycles 15, 19, 23...
REQ-031 Scenario: continue the REQ-030 run -> active[1] rises with the 3rd step[0]; step[1] first pulses with the 4th; active=111 after the 6th; step=111 at the 7th.
REQ-032 Scenario: game_over=010 asserted on a wrap edge -> state=10, no step that cycle, active and counters frozen for 50 cycles.
REQ-033 Scenario: restart and game_over=100 together while in HALT -> state=01, active=001, next step[0] after 4 cycles.
REQ-034 Scenario: speed=1 set mid-period -> the current period stays 4 cycles and following periods are 2 cycles; speed=2 -> step[0] high every cycle.
REQ-035 Scenario: reset_n pulsed low between clock edges mid-RUN -> outputs zero with no clock edge required, and no step pulses until a later restart.

Source files
------------

// File: rtl/fall_tick_generator.sv
// Fall-step tick generator: a speed-scaled prescaler paces per-column step pulses,
// and columns 2 and 3 are launched after a fixed number of column-1 steps.
module fall_tick_generator #(
  parameter int DIV    = 5000000,
  parameter int DELAY2 = 30,
  parameter int DELAY3 = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [2:0] game_over,
  input  logic [1:0] speed,
  output logic [2:0] step,
  output logic [2:0] active,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV + 1);
  localparam int CW = $clog2(DELAY3 + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   r_div_eff;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_step;
  logic [2:0]      r_active;

  logic            w_wrap;
  logic            w_valid_state;
  logic [CW-1:0]   w_cnt_next;

  // A shift that would leave a zero period is clamped to one cycle.
  function automatic logic [PW-1:0] div_for(input logic [1:0] s);
    logic [PW-1:0] d;
    d = PW'(DIV >> s);
    return (d == '0) ? PW'(1) : d;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(DELAY3)) ? c : c + CW'(1);
  endfunction

  assign w_wrap        = (r_presc == r_div_eff - PW'(1));
  assign w_cnt_next    = sat_inc(r_cnt);
  assign w_valid_state = (r_state == IDLE) || (r_state == RUN) || (r_state == HALT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_div_eff <= div_for(2'b00);
      r_cnt     <= '0;
      r_step    <= '0;
      r_active  <= '0;
    end else begin
      r_step <= '0;
      // Restart takes priority over game_over and over any wrap due this edge.
      if (restart && w_valid_state) begin
        r_state   <= RUN;
        r_presc   <= '0;
        r_cnt     <= '0;
        r_active  <= 3'b001;
        r_div_eff <= div_for(speed);
      end else begin
        case (r_state)
          IDLE: begin
            r_presc  <= '0;
            r_cnt    <= '0;
            r_active <= '0;
          end
          RUN: begin
            if (|game_over) begin
              r_state <= HALT;
            end else if (w_wrap) begin
              r_presc   <= '0;
              r_step    <= r_active;
              r_cnt     <= w_cnt_next;
              r_div_eff <= div_for(speed);
              if (w_cnt_next == CW'(DELAY2)) r_active[1] <= 1'b1;
              if (w_cnt_next == CW'(DELAY3)) r_active[2] <= 1'b1;
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          HALT: begin
          end
          default: begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_cnt    <= '0;
            r_active <= '0;
          end
        endcase
      end
    end
  end

  assign step   = r_step;
  assign active = r_active;
  assign state  = r_state;

endmodule

// File: tb/tb_fall_tick_generator.sv
// Randomised scoreboard bench for fall_tick_generator against a period/step-count model.
module tb_fall_tick_generator;

  localparam int DIV = 4;
  localparam int D2  = 3;
  localparam int D3  = 6;

  logic       clock;
  logic       reset_n;
  logic       restart;
  logic [2:0] game_over;
  logic [1:0] speed;
  logic [2:0] step;
  logic [2:0] active;
  logic [1:0] state;

  fall_tick_generator #(.DIV(DIV), .DELAY2(D2), .DELAY3(D3)) dut (
    .clock(clock), .reset_n(reset_n), .restart(restart), .game_over(game_over),
    .speed(speed), .step(step), .active(active), .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] act;
    logic [2:0] stp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Model: mode (0 idle, 1 run, 2 halt), cycles into the current period,
  // period length, and number of column-1 steps taken since launch.
  int         m_st = 0;
  int         m_phase = 0;
  int         m_period = DIV;
  int         m_wraps = 0;
  logic [2:0] m_step = '0;

  function automatic int eff(input logic [1:0] s);
    int d;
    d = DIV >> s;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic [2:0] act_of(input int w);
    return {(w >= D3), (w >= D2), 1'b1};
  endfunction

  function automatic exp_t expected_now();
    exp_t x;
    x.st  = m_st[1:0];
    x.act = (m_st == 0) ? 3'b000 : act_of(m_wraps);
    x.stp = m_step;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, want);
    end
  endtask

  task automatic model_edge();
    m_step = 3'b000;
    if (!reset_n) begin
      m_st = 0; m_phase = 0; m_wraps = 0;
    end else if (restart) begin
      m_st = 1; m_phase = 0; m_wraps = 0; m_period = eff(speed);
    end else if (m_st == 1) begin
      if (|game_over) begin
        m_st = 2;
      end else begin
        m_phase++;
        if (m_phase == m_period) begin
          m_step   = act_of(m_wraps);
          m_wraps++;
          m_phase  = 0;
          m_period = eff(speed);
        end
      end
    end
    q.push_back(expected_now());
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Reset dropped between edges must clear outputs without any clock edge.
  task automatic async_rst();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", {1'b0, state}, 3'b000);
    chk("async_active", active, 3'b000);
    chk("async_step", step, 3'b000);
    m_st = 0; m_phase = 0; m_wraps = 0; m_step = 3'b000;
    q.delete();
    q.push_back(expected_now());
    ticks(2);
    reset_n = 1'b1;
    ticks(8);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", {1'b0, state}, {1'b0, e.st});
      chk("active", active, e.act);
      chk("step", step, e.stp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; restart = 1'b0; game_over = 3'b000; speed = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_state", {1'b0, state}, 3'b000);
    chk("reset_active", active, 3'b000);
    chk("reset_step", step, 3'b000);
    ticks(3);
    reset_n = 1'b1;
    ticks(5);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    ticks(34);

    for (int i = 0; i < 10 && !(m_st == 1 && m_phase == m_period - 1); i++) tick();
    game_over = 3'b010;
    tick();
    game_over = 3'b000;
    ticks(50);

    restart = 1'b1;
    game_over = 3'b100;
    tick();
    restart = 1'b0;
    game_over = 3'b000;
    ticks(10);

    for (int i = 0; i < 10 && m_phase != 1; i++) tick();
    speed = 2'd1;
    ticks(12);
    speed = 2'd2;
    ticks(12);
    speed = 2'd0;
    ticks(5);

    async_rst();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ticks(12);

    for (int i = 0; i < 3000; i++) begin
      restart   = ($urandom_range(0, 59) == 0);
      game_over = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 699) == 0) async_rst();
      tick();
    end
    restart = 1'b0;
    game_over = 3'b000;
    tick();

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
